audio_seq_player: RTL and testbench

AUDIO_SEQ_PLAYER -- requirements
Module: audio_seq_player

---
 rtl/audio_seq_player.sv | 150 +++++++++++++++
 tb/tb_audio_seq_player.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_seq_player.sv
// Beat-sequenced square-wave tone player: steps a beat index through an external
// score table and renders one duty-controlled PWM tone per channel.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | stopped, beat_idx and beat counter parked at 0
// S_PLAY  | beat counter running, tones rendering
// S_PAUSE | beat counter and beat_idx frozen, tones silent
module audio_seq_player #(
    parameter int NUM_CH    = 2,
    parameter int BEAT_DIV  = 12_500_000,
    parameter int TRACK_LEN = 128,
    parameter int IDX_W     = 8,
    parameter int PER_W     = 20,
    parameter int DUTY_W    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    play,
    input  logic                    pause,
    input  logic                    stop,
    input  logic                    loop,
    input  logic [DUTY_W-1:0]       duty,
    input  logic [NUM_CH*PER_W-1:0] tone_per,
    output logic [IDX_W-1:0]        beat_idx,
    output logic [NUM_CH-1:0]       pwm,
    output logic                    playing,
    output logic                    done
);

    localparam int CNT_W  = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int PROD_W = PER_W + DUTY_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TRACK_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
    logic [IDX_W-1:0] beat_idx_n;
    logic             done_n;
    logic             in_play;
    logic             idx_chg;

    logic [PER_W-1:0]  tone_cnt   [NUM_CH];
    logic [PER_W-1:0]  tone_cnt_n [NUM_CH];
    logic [NUM_CH-1:0] pwm_n;

    assign in_play = (state == S_PLAY);

    // stop outranks everything; pause outranks play while playing
    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        beat_idx_n = beat_idx;
        done_n     = 1'b0;
        if (stop) begin
            state_n    = S_IDLE;
            beat_cnt_n = '0;
            beat_idx_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play) begin
                        state_n    = S_PLAY;
                        beat_cnt_n = '0;
                        beat_idx_n = '0;
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        state_n = S_PAUSE;
                    end else if (beat_cnt == CNT_LAST) begin
                        beat_cnt_n = '0;
                        if (beat_idx < IDX_LAST) begin
                            beat_idx_n = beat_idx + IDX_W'(1);
                        end else if (loop) begin
                            beat_idx_n = '0;
                        end else begin
                            state_n    = S_IDLE;
                            beat_idx_n = '0;
                            done_n     = 1'b1;
                        end
                    end else begin
                        beat_cnt_n = beat_cnt + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (play) begin
                        state_n = S_PLAY;
                    end
                end
                default: begin
                    state_n    = S_IDLE;
                    beat_cnt_n = '0;
                    beat_idx_n = '0;
                end
            endcase
        end
    end

    assign idx_chg = (beat_idx_n != beat_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            beat_idx <= '0;
            done     <= 1'b0;
            playing  <= 1'b0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            beat_idx <= beat_idx_n;
            done     <= done_n;
            playing  <= (state_n == S_PLAY);
        end
    end

    // Tone counters restart on every new note so each note begins phase-aligned
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [PER_W-1:0]  per;
        logic [PROD_W-1:0] prod;
        logic [PER_W-1:0]  high_time;

        assign per       = tone_per[k*PER_W +: PER_W];
        assign prod      = PROD_W'(per) * PROD_W'(duty);
        assign high_time = PER_W'(prod >> DUTY_W);

        assign tone_cnt_n[k] = (!in_play || (per == '0) || idx_chg ||
                                (tone_cnt[k] >= per - PER_W'(1)))
                               ? '0 : tone_cnt[k] + PER_W'(1);
        assign pwm_n[k] = in_play && (per != '0) && (tone_cnt[k] < high_time);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                tone_cnt[k] <= '0;
            end
            pwm <= '0;
        end else begin
            tone_cnt <= tone_cnt_n;
            pwm      <= pwm_n;
        end
    end

endmodule

// File: tb/tb_audio_seq_player.sv
// Randomised and directed bench for audio_seq_player against a track-position model.
module tb_audio_seq_player;

    localparam int NUM_CH    = 2;
    localparam int BEAT_DIV  = 10;
    localparam int TRACK_LEN = 4;
    localparam int IDX_W     = 8;
    localparam int PER_W     = 8;
    localparam int DUTY_W    = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    play, pause, stop, loop;
    logic [DUTY_W-1:0]       duty;
    logic [NUM_CH*PER_W-1:0] tone_per;
    logic [IDX_W-1:0]        beat_idx;
    logic [NUM_CH-1:0]       pwm;
    logic                    playing, done;
    logic [11:0]             obs;

    int vectors     = 0;
    int miscompares = 0;

    // model: mode 0 stopped, 1 running, 2 frozen; pos = cycles into the track
    int       m_mode;
    int       m_pos;
    int       m_ph [NUM_CH];
    bit       m_done;
    bit [1:0] m_pwm;

    audio_seq_player #(
        .NUM_CH(NUM_CH), .BEAT_DIV(BEAT_DIV), .TRACK_LEN(TRACK_LEN),
        .IDX_W(IDX_W), .PER_W(PER_W), .DUTY_W(DUTY_W)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .loop(loop), .duty(duty), .tone_per(tone_per), .beat_idx(beat_idx),
        .pwm(pwm), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {beat_idx, playing, done, pwm};

    function automatic logic [11:0] model_vec();
        logic [7:0] idx;
        idx = 8'(m_pos / BEAT_DIV);
        return {idx, (m_mode == 1), m_done, m_pwm};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        m_done = 1'b0;
        m_pwm  = 2'b00;
        for (int k = 0; k < NUM_CH; k++) m_ph[k] = 0;
    endtask

    task automatic model_step();
        int per [NUM_CH];
        int old_mode, old_idx, new_idx, high;
        bit [1:0] pwm_nx;
        old_mode = m_mode;
        old_idx  = m_pos / BEAT_DIV;
        for (int k = 0; k < NUM_CH; k++) begin
            per[k]    = int'(tone_per[k*PER_W +: PER_W]);
            high      = ((per[k] * int'(duty)) / (1 << DUTY_W)) % (1 << PER_W);
            pwm_nx[k] = (m_mode == 1) && (per[k] != 0) && (m_ph[k] < high);
        end
        m_done = 1'b0;
        if (stop) begin
            m_mode = 0;
            m_pos  = 0;
        end else if (m_mode == 1 && pause) begin
            m_mode = 2;
        end else if (m_mode == 0 && play) begin
            m_mode = 1;
            m_pos  = 0;
        end else if (m_mode == 2 && play) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_pos++;
            if (m_pos == TRACK_LEN * BEAT_DIV) begin
                m_pos = 0;
                if (!loop) begin
                    m_mode = 0;
                    m_done = 1'b1;
                end
            end
        end
        new_idx = m_pos / BEAT_DIV;
        for (int k = 0; k < NUM_CH; k++) begin
            if (old_mode != 1 || per[k] == 0 || new_idx != old_idx) m_ph[k] = 0;
            else if (m_ph[k] + 1 >= per[k]) m_ph[k] = 0;
            else m_ph[k] = m_ph[k] + 1;
        end
        m_pwm = pwm_nx;
    endtask

    // one clock: apply pulses, advance model at the edge, sample 1 ns later
    task automatic cyc(input bit p, input bit pa, input bit s);
        play  = p;
        pause = pa;
        stop  = s;
        @(posedge clk);
        model_step();
        #1;
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0;
        duty = 4'd8; tone_per = {8'd6, 8'd8};
        model_reset();
        #12;
        vectors++;
        if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_once_through();
        int done_at = -1;
        int done_cnt = 0;
        loop = 1'b0;
        tone_per = {8'($urandom_range(0, 30)), 8'($urandom_range(1, 30))};
        duty = 4'($urandom_range(0, 15));
        cyc(1, 0, 0);
        for (int i = 1; i <= 45; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL once cyc %0d: got %h expected %h", i, obs, model_vec());
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i == 10 || i == 20 || i == 30) begin
                vectors++;
                if (beat_idx !== 8'(i / 10)) begin
                    miscompares++;
                    $display("FAIL once_step cyc %0d: beat_idx %0d expected %0d", i, beat_idx, i / 10);
                end
            end
        end
        vectors++;
        if (done_at != 40 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL once_done: at %0d count %0d expected at 40 count 1", done_at, done_cnt);
        end
        vectors++;
        if (playing !== 1'b0 || beat_idx !== 8'd0) begin
            miscompares++;
            $display("FAIL once_end: playing %b beat_idx %0d expected 0 0", playing, beat_idx);
        end
    endtask

    task automatic test_loop();
        int done_cnt = 0;
        loop = 1'b1;
        tone_per = {8'd5, 8'd9};
        duty = 4'd5;
        cyc(1, 0, 0);
        for (int i = 1; i <= 85; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL loop cyc %0d: got %h expected %h", i, obs, model_vec());
            end
            vectors++;
            if (done !== 1'b0 || playing !== 1'b1) begin
                miscompares++;
                $display("FAIL loop_run cyc %0d: done %b playing %b expected 0 1", i, done, playing);
            end
            if (i == 39 || i == 40) begin
                vectors++;
                if (beat_idx !== ((i == 39) ? 8'd3 : 8'd0)) begin
                    miscompares++;
                    $display("FAIL loop_wrap cyc %0d: beat_idx %0d", i, beat_idx);
                end
            end
        end
        loop = 1'b0;
        for (int i = 0; i < 45; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL loop_exit cyc %0d: got %h expected %h", i, obs, model_vec());
            end
            if (done) done_cnt++;
        end
        vectors++;
        if (done_cnt != 1 || playing !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_done: count %0d playing %b expected 1 0", done_cnt, playing);
        end
    endtask

    task automatic test_pause_resume();
        int n = 0;
        loop = 1'b0;
        tone_per = {8'd5, 8'd6};
        duty = 4'd10;
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0);
        vectors++;
        if (beat_idx !== 8'd1) begin
            miscompares++;
            $display("FAIL pause_pos: beat_idx %0d expected 1", beat_idx);
        end
        cyc(0, 1, 0);
        for (int j = 1; j <= 25; j++) begin
            cyc(0, 0, 0);
            vectors++;
            if (obs !== model_vec() || pwm !== 2'b00 || beat_idx !== 8'd1) begin
                miscompares++;
                $display("FAIL pause_hold cyc %0d: got %h expected %h", j, obs, model_vec());
            end
        end
        cyc(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            n++;
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL resume cyc %0d: got %h expected %h", n, obs, model_vec());
            end
            if (beat_idx == 8'd2) break;
        end
        vectors++;
        if (n != 6) begin
            miscompares++;
            $display("FAIL resume_tick: tick after %0d clks expected 6", n);
        end
    endtask

    task automatic test_tone_shape();
        loop = 1'b1;
        tone_per = {8'd0, 8'd8};
        duty = 4'd8;
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (pwm !== {1'b0, (i <= 4)} || obs !== model_vec()) begin
                miscompares++;
                $display("FAIL tone_shape cyc %0d: pwm %b expected %b", i, pwm, {1'b0, (i <= 4)});
            end
        end
        duty = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (pwm !== 2'b00 || obs !== model_vec()) begin
                miscompares++;
                $display("FAIL tone_duty0 cyc %0d: pwm %b expected 00", i, pwm);
            end
        end
        cyc(0, 0, 1);
    endtask

    task automatic test_simultaneous();
        loop = 1'b0;
        duty = 4'd7;
        tone_per = {8'd3, 8'd4};
        cyc(1, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0);
        cyc(1, 0, 1);
        vectors++;
        if (obs !== model_vec() || playing !== 1'b0 || beat_idx !== 8'd0) begin
            miscompares++;
            $display("FAIL stop_play: got %h expected idle", obs);
        end
        cyc(1, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0);
        cyc(1, 1, 0);
        vectors++;
        if (obs !== model_vec() || playing !== 1'b0 || beat_idx !== 8'd1) begin
            miscompares++;
            $display("FAIL play_pause: got %h expected paused at beat 1", obs);
        end
        cyc(1, 0, 0);
        vectors++;
        if (playing !== 1'b1 || beat_idx !== 8'd1) begin
            miscompares++;
            $display("FAIL pause_resume: playing %b beat_idx %0d expected 1 1", playing, beat_idx);
        end
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 39; i++) cyc(0, 0, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs !== model_vec() || done !== 1'b0 || playing !== 1'b0 || beat_idx !== 8'd0) begin
                miscompares++;
                $display("FAIL stop_final cyc %0d: got %h expected %h", i, obs, model_vec());
            end
            cyc(0, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        loop = 1'b1;
        tone_per = {8'd4, 8'd6};
        duty = 4'd9;
        cyc(1, 0, 0);
        for (int i = 0; i < 13; i++) cyc(0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, 12'h000);
        end
        #7;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            vectors++;
            if (obs !== model_vec() || beat_idx !== 8'd0 || playing !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_autostart cyc %0d: got %h expected %h", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 800; i++) begin
            if (i % 23 == 0) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    tone_per[k*PER_W +: PER_W] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
                end
                duty = 4'($urandom_range(0, 15));
                loop = 1'($urandom_range(0, 1));
            end
            r = int'($urandom_range(0, 99));
            cyc((r < 8) || (r == 12), (r >= 8 && r < 12) || (r == 12), (r == 13) || (r == 14));
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h expected %h", i, obs, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_once_through();
        test_loop();
        test_pause_resume();
        test_tone_shape();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
